// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, W+1 cycle latency.
// Optional digit/overflow checking and saturation: define BCD2BIN_CHECK_EN.
module bcd2bin_seq #(
  parameter  int W  = 18,
  localparam int BW = W + (W - 4) / 3 + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [BW-1:0] i_bcd,
  output logic          o_busy,
  output logic          o_done,
  output logic [W-1:0]  o_bin,
  output logic          o_err_digit,
  output logic          o_err_ovf
);

  localparam int ND = (BW + 3) / 4;
  localparam int FW = ND * 4;
  localparam int WW = FW + W;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // After a right shift a digit is >=8 exactly when it received the carry bit (worth 5, not 8).
  function automatic logic [FW-1:0] fix_digits(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r = f;
    for (int i = 0; i < ND; i++) begin
      if (f[i*4 +: 4] >= 4'd8) r[i*4 +: 4] = f[i*4 +: 4] - 4'd3;
      else                     r[i*4 +: 4] = f[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic any_bad_digit(input logic [FW-1:0] f);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (f[i*4 +: 4] > 4'd9) bad = 1'b1;
      else                    bad = bad;
    end
    return bad;
  endfunction

  logic [1:0]    r_state;
  logic [WW-1:0] r_work;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_bin;
  logic          r_err_digit;
  logic          r_err_ovf;

  logic [FW-1:0] w_bcd_ext;
  logic [WW-1:0] w_shifted;
  logic [WW-1:0] w_iter;
  logic          w_bad_digit;
  logic          w_ovf;
  logic [W-1:0]  w_res;

  assign w_bcd_ext = FW'(i_bcd);
  assign w_shifted = {1'b0, r_work[WW-1:1]};
  assign w_iter    = {fix_digits(w_shifted[WW-1:W]), w_shifted[W-1:0]};

  // Final result selection from the working register at the end of the shift phase.
  always_comb begin
    w_bad_digit = 1'b0;
    w_ovf       = 1'b0;
    w_res       = r_work[W-1:0];
`ifdef BCD2BIN_CHECK_EN
    w_bad_digit = any_bad_digit(w_bcd_ext);
    w_ovf       = ~r_err_digit & (|r_work[WW-1:W]);
    if (r_err_digit)  w_res = {W{1'b0}};
    else if (w_ovf)   w_res = {W{1'b1}};
    else              w_res = r_work[W-1:0];
`else
    w_bad_digit = 1'b0;
    w_ovf       = 1'b0;
    w_res       = r_work[W-1:0];
`endif
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_work      <= {WW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bin       <= {W{1'b0}};
      r_err_digit <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_work      <= {w_bcd_ext, {W{1'b0}}};
            r_cnt       <= {CW{1'b0}};
            r_err_digit <= w_bad_digit;
            r_busy      <= 1'b1;
            r_state     <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (r_cnt == CW'(W)) begin
            r_bin     <= w_res;
            r_err_ovf <= w_ovf;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_work <= w_iter;
            r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_bin       = r_bin;
  assign o_err_digit = r_err_digit;
  assign o_err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq (W=18): directed cases plus randomized round trips.
module tb_bcd2bin_seq;

`ifdef BCD2BIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [22:0] i_bcd;
  logic        o_busy;
  logic        o_done;
  logic [17:0] o_bin;
  logic        o_err_digit;
  logic        o_err_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] prev_bin = 18'd0;
  logic        prev_ovf = 1'b0;

  bcd2bin_seq #(.W(18)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_bcd(i_bcd),
    .o_busy(o_busy), .o_done(o_done), .o_bin(o_bin),
    .o_err_digit(o_err_digit), .o_err_ovf(o_err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits, then the check/saturate/wrap rules.
  function automatic void model(input logic [22:0] b, output logic [17:0] eb,
                                output logic ed, output logic eo, output logic bad);
    longint v, p;
    logic [23:0] bx;
    int d;
    v = 0; p = 1; bad = 1'b0; bx = {1'b0, b};
    for (int i = 0; i < 6; i++) begin
      d = int'(bx[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      v += d * p;
      p *= 10;
    end
    if (CHK) begin
      ed = bad;
      if (bad)              begin eb = 18'd0;       eo = 1'b0; end
      else if (v > 262143)  begin eb = 18'h3FFFF;   eo = 1'b1; end
      else                  begin eb = v[17:0];     eo = 1'b0; end
    end else begin
      ed = 1'b0; eo = 1'b0; eb = v[17:0];
    end
  endfunction

  function automatic logic [22:0] to_bcd(input int x);
    logic [23:0] r;
    int t;
    r = 24'd0; t = x;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r[22:0];
  endfunction

  task automatic run(input logic [22:0] b, input string tag);
    int lat, bcnt;
    logic [17:0] eb;
    logic ed, eo, bad;
    model(b, eb, ed, eo, bad);
    @(negedge clk); i_bcd = b; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    chk({tag, ":busy_rise"}, o_busy, 1);
    chk({tag, ":err_digit_early"}, o_err_digit, ed);
    chk({tag, ":bin_held_at_start"}, o_bin, prev_bin);
    chk({tag, ":ovf_held_at_start"}, o_err_ovf, prev_ovf);
    lat = 0; bcnt = 1;
    while (o_done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (o_busy === 1'b1) bcnt++;
    end
    chk({tag, ":latency"}, lat, 19);
    if (CHK || !bad) chk({tag, ":bin"}, o_bin, eb);
    chk({tag, ":err_digit"}, o_err_digit, ed);
    chk({tag, ":err_ovf"}, o_err_ovf, eo);
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, o_done, 0);
    chk({tag, ":busy_fall"}, o_busy, 0);
    chk({tag, ":busy_cycles"}, bcnt, 20);
    if (CHK || !bad) prev_bin = eb;
    else             prev_bin = o_bin;
    prev_ovf = eo;
  endtask

  initial begin
    logic [31:0] rnd;
    int x, ndone;
    i_rst = 1'b1; i_start = 1'b0; i_bcd = 23'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_bin", o_bin, 0);
    chk("reset_err_digit", o_err_digit, 0);
    chk("reset_err_ovf", o_err_ovf, 0);
    @(negedge clk); i_rst = 1'b0;

    run(23'h000000, "zero");
    run(23'h262143, "max");
    run(23'h001234, "d1234");
    run(23'h262144, "ovf");
    run(23'h00001A, "bad_digit");
    run(23'h000009, "d9");
    run(23'h000010, "d10");
    run(23'h099999, "d99999");
    run(23'h100000, "d100000");
    run(23'h7FFFFF, "all_f");

    // Outputs hold while idle regardless of the input bus.
    @(negedge clk); i_bcd = 23'h555555;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold_bin", o_bin, prev_bin);

    // A start during SHIFT is ignored: one done, first operand's result.
    @(negedge clk); i_bcd = to_bcd(4321); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); i_bcd = to_bcd(777); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) ndone++;
    end
    chk("ignored_start_ndone", ndone, 1);
    chk("ignored_start_bin", o_bin, 4321);
    prev_bin = 18'd4321; prev_ovf = 1'b0;

    // Reset at iteration 7 aborts the conversion.
    run(23'h262143, "pre_reset");
    @(negedge clk); i_bcd = to_bcd(55555); i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); i_rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_bin", o_bin, 0);
    chk("abort_err_digit", o_err_digit, 0);
    chk("abort_err_ovf", o_err_ovf, 0);
    @(negedge clk); i_rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    prev_bin = 18'd0; prev_ovf = 1'b0;
    run(to_bcd(99999), "after_reset");

    // Random round trips through a decimal encoding.
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(0, 262143));
      run(to_bcd(x), "roundtrip");
      chk("roundtrip_value", o_bin, x);
    end

    // Random raw vectors, including invalid digits and overflow.
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom();
      run(rnd[22:0], "raw");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
